pkt_tx: RTL
===========

PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 Parameter CLK_HZ, default 65_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 Parameter CLK_PER_BIT, default 6768, clocks per line bit (16 samples x 423 clocks, matching the receiver sampler).
REQ-004 Parameter GAP_COUNT, default 130_000, idle-high clocks enforced after each packet (2 ms at 65 MHz).
REQ-005 Port clk_in  input  1  system clock; one clock domain only.
REQ-006 Port rst_in  input  1  reset, synchronous, active-high.
REQ-007 Port data_in  input  162  payload, sampled only on acceptance.
REQ-008 Port send  input  1  request to transmit; accepted in any cycle where send=1 and ready=1.
REQ-009 Port ready  output  1  high when idle and able to accept a packet.
REQ-010 Port tx  output  1  serial line, idle high.

Function
REQ-011 Line format: 8N1 frames; start bit 0, 8 data bits LSB first, 1 stop bit 1; each bit held exactly CLK_PER_BIT cycles.
REQ-012 Packet is 21 bytes: byte k = data_in[8k+7:8k] for k=0..19; byte 20 = {6'b0, data_in[161:160]}; byte 0 sent first.
REQ-013 Acceptance at clock edge N latches data_in into an internal register; ready=0 and tx=0 (start bit of byte 0) from edge N+1.
REQ-014 Stop bit of byte k is followed immediately by the start bit of byte k+1; no inter-byte idle.
REQ-015 FSM states IDLE, START, DATA, STOP, GAP; IDLE->START on acceptance; START->DATA after CLK_PER_BIT; DATA->STOP after 8th bit; STOP->START if bytes remain, else STOP->GAP; GAP->IDLE after GAP_COUNT cycles.
REQ-016 tx=1 in IDLE, STOP and GAP; ready=1 only in IDLE.
REQ-017 send while ready=0 is ignored, not queued; data_in changes after acceptance do not affect the packet in flight.
REQ-018 Packet duration from first start bit to end of last stop bit is exactly 21*10*CLK_PER_BIT cycles (22*10 with checksum); ready returns high exactly GAP_COUNT cycles later.
REQ-019 Baud counter width is $clog2(CLK_PER_BIT), gap counter width is $clog2(GAP_COUNT+1); counters wrap only via explicit reload, never by overflow.
REQ-020 send held continuously high starts a new packet in the first IDLE cycle after the gap.

Reset
REQ-021 rst_in=1 at any edge forces next cycle: state IDLE, tx=1, ready=1, all counters and byte/bit indices zero.
REQ-022 Reset mid-packet truncates the frame; no further bits of the aborted packet are emitted and no gap is enforced.
REQ-023 send asserted in the same cycle as rst_in is ignored.

Configuration
REQ-024 Macro PKT_TX_CHECKSUM_EN defined: a 22nd byte equal to XOR of bytes 0..20 is appended after byte 20, same framing.
REQ-025 Macro PKT_TX_CHECKSUM_EN undefined: packet is exactly 21 bytes and no checksum logic is present.

Structure
REQ-026 Package pkt_tx_pkg holds the state enum, PAYLOAD_W=162, NUM_BYTES=21, and the checksum byte-count constant.
REQ-027 One sub-module uat_byte_tx serializes a single byte (START/DATA/STOP timing, done pulse); pkt_tx sequences bytes, checksum and gap.

Verification (CLK_PER_BIT=4, GAP_COUNT=10 unless stated)
REQ-028 data_in=162'h1 with send pulse -> tx low 4 cycles, then bit pattern 1,0,0,0,0,0,0,0, stop high; remaining 20 bytes all 0x00; ready high 840+10 cycles after acceptance edge +1.
REQ-029 data_in bits [161:160]=2'b11, rest 0 -> byte 20 decodes as 0x03; bytes 0..19 decode as 0x00.
REQ-030 send pulsed at cycle 100 after acceptance, data_in changed -> no second packet, first packet unchanged.
REQ-031 rst_in asserted during DATA of byte 5 -> tx=1, ready=1 next cycle; subsequent send starts a fresh packet at byte 0.
REQ-032 With PKT_TX_CHECKSUM_EN, data_in bytes 0=0x5A, 1=0xFF, rest 0 -> 22nd byte 0xA5, packet duration 880 cycles.
REQ-033 send held high across two packets -> second start bit occurs exactly GAP_COUNT+1 cycles after end of first packet's final stop bit.

Source files
------------

// File: rtl/pkt_tx_pkg.sv
// pkt_tx_pkg -- shared types and constants for the packet transmitter.
//   state_e      : byte serializer line states (IDLE/START/DATA/STOP/GAP)
//   phase_e      : packet sequencer phases
//   PAYLOAD_W    : payload width in bits
//   NUM_BYTES    : payload bytes per packet
//   CSUM_NUM_BYTES : bytes per packet when the checksum byte is appended
//   payload_byte : extracts byte k of a payload (byte 20 holds the top 2 bits)
//   payload_xor  : XOR of all payload bytes (checksum builds only)
package pkt_tx_pkg;

  localparam int unsigned PAYLOAD_W      = 162;
  localparam int unsigned NUM_BYTES      = 21;
  localparam int unsigned CSUM_NUM_BYTES = NUM_BYTES + 1;
  localparam int unsigned IDX_W          = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SEND,
    P_GAP
  } phase_e;

  // Zero-padding the payload to a whole number of bytes makes byte 20
  // come out as {6'b0, d[161:160]} with a plain indexed part-select.
  function automatic logic [7:0] payload_byte(input logic [PAYLOAD_W-1:0] d,
                                              input logic [IDX_W-1:0] k);
    logic [NUM_BYTES*8-1:0] p;
    p = {{(NUM_BYTES*8-PAYLOAD_W){1'b0}}, d};
    if (k < IDX_W'(NUM_BYTES)) begin
      return p[int'(k)*8 +: 8];
    end
    return '0;
  endfunction

`ifdef PKT_TX_CHECKSUM_EN
  function automatic logic [7:0] payload_xor(input logic [PAYLOAD_W-1:0] d);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      x ^= payload_byte(d, IDX_W'(i));
    end
    return x;
  endfunction
`endif

endpackage

// File: rtl/pkt_tx_byte.sv
// uat_byte_tx -- serializes one byte as an 8N1 frame (start 0, 8 data bits
// LSB first, stop 1), each bit held CLK_PER_BIT clocks.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   start_i : load byte_i; honoured in IDLE or in the last cycle of STOP
//   byte_i  : byte to send
//   tx_o    : serial line, idle high
//   done_o  : one-cycle pulse in the final cycle of the stop bit
module uat_byte_tx
  import pkt_tx_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 6768
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_o    = 1'b1;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (start_i) begin
          state_d = S_START;
          sh_d    = byte_i;
          bit_d   = '0;
        end
      end
      S_START: begin
        tx_o = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_o = sh_q[0];
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        // A start request in the last stop cycle chains straight into the
        // next start bit so consecutive bytes have no idle between them.
        if (bit_end) begin
          done_o = 1'b1;
          if (start_i) begin
            state_d = S_START;
            sh_d    = byte_i;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: rtl/pkt_tx.sv
// pkt_tx -- sends a 162-bit payload as 21 back-to-back 8N1 bytes (byte 0
// first), then holds the line idle-high for GAP_COUNT clocks.
// Defining PKT_TX_CHECKSUM_EN appends a 22nd byte = XOR of bytes 0..20.
//   clk_in  : system clock
//   rst_in  : synchronous active-high reset
//   data_in : payload, latched on acceptance
//   send    : transmit request, accepted when send && ready
//   ready   : idle and able to accept a packet
//   tx      : serial line, idle high
module pkt_tx
  import pkt_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 65_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned CLK_PER_BIT = 6768,
  parameter int unsigned GAP_COUNT   = 130_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [PAYLOAD_W-1:0] data_in,
  input  logic                 send,
  output logic                 ready,
  output logic                 tx
);

`ifdef PKT_TX_CHECKSUM_EN
  localparam int unsigned TX_BYTES = CSUM_NUM_BYTES;
`else
  localparam int unsigned TX_BYTES = NUM_BYTES;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_BYTES - 1);
  localparam int unsigned GAP_W = $clog2(GAP_COUNT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_COUNT - 1);

  if (BAUD_RATE == 0 || CLK_HZ < BAUD_RATE || CLK_PER_BIT < 2 || GAP_COUNT < 1)
  begin : g_cfg_check
    $error("pkt_tx: invalid clock/baud/gap parameters");
  end

  phase_e               phase_q, phase_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [IDX_W-1:0]     next_idx;
  logic [7:0]           next_byte;
  logic                 accept;
  logic                 byte_start;
  logic [7:0]           byte_val;
  logic                 byte_done;

  assign next_idx = idx_q + 1'b1;

`ifdef PKT_TX_CHECKSUM_EN
  assign next_byte = (next_idx == IDX_W'(NUM_BYTES)) ? payload_xor(data_q)
                                                     : payload_byte(data_q, next_idx);
`else
  assign next_byte = payload_byte(data_q, next_idx);
`endif

  always_comb begin
    phase_d    = phase_q;
    data_d     = data_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    ready      = (phase_q == P_IDLE);
    accept     = (phase_q == P_IDLE) && send && !rst_in;
    byte_start = 1'b0;
    byte_val   = next_byte;
    case (phase_q)
      P_IDLE: begin
        // Byte 0 comes straight from data_in so its start bit appears on the
        // cycle after acceptance, in parallel with latching the payload.
        if (accept) begin
          phase_d    = P_SEND;
          data_d     = data_in;
          idx_d      = '0;
          byte_start = 1'b1;
          byte_val   = payload_byte(data_in, '0);
        end
      end
      P_SEND: begin
        if (byte_done) begin
          if (idx_q == LAST_IDX) begin
            phase_d = P_GAP;
            gap_d   = '0;
          end else begin
            idx_d      = next_idx;
            byte_start = 1'b1;
          end
        end
      end
      P_GAP: begin
        if (gap_q == GAP_LAST) begin
          phase_d = P_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: phase_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase_q <= P_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      phase_q <= phase_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  uat_byte_tx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_byte_tx (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .start_i(byte_start),
    .byte_i (byte_val),
    .tx_o   (tx),
    .done_o (byte_done)
  );

endmodule
